// File: rtl/pio_ser_pkg.sv
// Shared types and constants for the PIO-to-LED-chain serializer.
package pio_ser_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH    = 3'd4
    } ser_state_e;

    // Divider counter is wide enough for any CLK_DIV in 1..255.
    localparam int unsigned DIV_CNT_W = $clog2(256);

    // Completed-frame counter width.
    localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/pio_ser_tick.sv
// Clock-enable divider: asserts tick once every CLK_DIV clk cycles while
// not held in clear. Counting always restarts from zero after clear drops.
module pio_ser_tick
    import pio_ser_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam logic [DIV_CNT_W-1:0] LAST_CNT  = DIV_CNT_W'(CLK_DIV - 1);
    localparam logic [DIV_CNT_W-1:0] ZERO_CNT  = {DIV_CNT_W{1'b0}};

    logic [DIV_CNT_W-1:0] cnt_q;
    logic [DIV_CNT_W-1:0] cnt_d;

    // Next count: hold at zero under clear, wrap after the last count.
    always_comb begin
        if (clear) begin
            cnt_d = ZERO_CNT;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = ZERO_CNT;
        end else begin
            cnt_d = cnt_q + DIV_CNT_W'(1);
        end
    end

    assign tick = (!clear) && (cnt_q == LAST_CNT);

    // Divider counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= ZERO_CNT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pio_led_serializer.sv
// Shifts every new PIO output word out to a 74HC595-style daisy chain over
// sclk/sdata/latch. Updates arriving mid-frame are coalesced so the chain
// always ends up holding the most recent word.
module pio_led_serializer
    import pio_ser_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_W-1:0]      pio_word,
    input  logic                   force_update,
    output logic                   sclk,
    output logic                   sdata,
    output logic                   latch,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int unsigned BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);
    // Bit position that goes out next on the wire.
    localparam int unsigned FIRST_IDX = MSB_FIRST ? (DATA_W - 1) : 0;

    // Drop the bit just presented and bring the following one to FIRST_IDX.
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        if (MSB_FIRST) begin
            return {w[DATA_W-2:0], 1'b0};
        end else begin
            return {1'b0, w[DATA_W-1:1]};
        end
    endfunction

    ser_state_e             state_q, state_d;
    logic [DATA_W-1:0]      shift_reg_q, shift_reg_d;
    logic [DATA_W-1:0]      shadow_q, shadow_d;
    logic                   pending_q, pending_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   sclk_q, sclk_d;
    logic                   sdata_q, sdata_d;
    logic                   latch_q, latch_d;
    logic                   busy_q, busy_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

    logic tick_s;
    logic tick_clear_s;

    // Divider is held in IDLE and restarted in LOAD so every phase is CLK_DIV long.
    assign tick_clear_s = (state_q == IDLE) || (state_q == LOAD);

    pio_ser_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tick_clear_s),
        .tick    (tick_s)
    );

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pending_q || force_update || (pio_word != shadow_q)) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (tick_s) begin
                    state_d = SHIFT_HI;
                end else begin
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_HI: begin
                if (tick_s && (bit_cnt_q == LAST_BIT)) begin
                    state_d = LATCH;
                end else if (tick_s) begin
                    state_d = SHIFT_LO;
                end else begin
                    state_d = SHIFT_HI;
                end
            end
            LATCH: begin
                if (tick_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = LATCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: capture in LOAD, advance one bit per sclk period, count frames.
    always_comb begin
        shift_reg_d   = shift_reg_q;
        shadow_d      = shadow_q;
        bit_cnt_d     = bit_cnt_q;
        sdata_d       = sdata_q;
        frame_count_d = frame_count_q;

        // A retransmit request always wins over the clear that LOAD performs.
        if (force_update) begin
            pending_d = 1'b1;
        end else if (state_q == LOAD) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            LOAD: begin
                shift_reg_d = shift_out(pio_word);
                shadow_d    = pio_word;
                bit_cnt_d   = {BIT_CNT_W{1'b0}};
                sdata_d     = pio_word[FIRST_IDX];
            end
            SHIFT_HI: begin
                // sdata only moves on the falling sclk edge, never across a rising one.
                if (tick_s && (bit_cnt_q != LAST_BIT)) begin
                    bit_cnt_d   = bit_cnt_q + BIT_CNT_W'(1);
                    shift_reg_d = shift_out(shift_reg_q);
                    sdata_d     = shift_reg_q[FIRST_IDX];
                end else begin
                    bit_cnt_d   = bit_cnt_q;
                end
            end
            LATCH: begin
                if (tick_s) begin
                    frame_count_d = frame_count_q + FRAME_CNT_W'(1);
                    sdata_d       = 1'b0;
                end else begin
                    frame_count_d = frame_count_q;
                end
            end
            default: begin
                shadow_d = shadow_q;
            end
        endcase
    end

    // Output decode from the upcoming state so pins are glitch-free flops.
    always_comb begin
        sclk_d  = (state_d == SHIFT_HI);
        latch_d = (state_d == LATCH);
        busy_d  = (state_d != IDLE);
    end

    // All state and output registers; reset forces a full resend afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            shift_reg_q   <= {DATA_W{1'b0}};
            shadow_q      <= {DATA_W{1'b0}};
            pending_q     <= 1'b1;
            bit_cnt_q     <= {BIT_CNT_W{1'b0}};
            sclk_q        <= 1'b0;
            sdata_q       <= 1'b0;
            latch_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= {FRAME_CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            shift_reg_q   <= shift_reg_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            bit_cnt_q     <= bit_cnt_d;
            sclk_q        <= sclk_d;
            sdata_q       <= sdata_d;
            latch_q       <= latch_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign sclk        = sclk_q;
    assign sdata       = sdata_q;
    assign latch       = latch_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pio_led_serializer.sv
// Bench for pio_led_serializer: two instances (CLK_DIV=4/MSB first and
// CLK_DIV=1/LSB first) checked every cycle against a frame-timeline model.
module tb_pio_led_serializer;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pw1, pw2;
    logic        fu1, fu2;
    logic        sclk1, sdata1, latch1, busy1;
    logic        sclk2, sdata2, latch2, busy2;
    logic [15:0] fc1, fc2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pio_led_serializer #(.DATA_W(32), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .pio_word(pw1), .force_update(fu1),
        .sclk(sclk1), .sdata(sdata1), .latch(latch1), .busy(busy1), .frame_count(fc1));

    pio_led_serializer #(.DATA_W(32), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .pio_word(pw2), .force_update(fu2),
        .sclk(sclk2), .sdata(sdata2), .latch(latch2), .busy(busy2), .frame_count(fc2));

    // ---------------- model: frame described by its cycle offset from LOAD
    bit          m_busy   [2];
    int          m_k      [2];
    logic [31:0] m_word   [2];
    logic [31:0] m_shadow [2];
    bit          m_pend   [2];
    logic [15:0] m_fc     [2];

    function automatic int divv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int flen(input int i);
        return 1 + 2 * divv(i) * W + divv(i);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_busy[i] = 1'b0; m_k[i] = 0; m_word[i] = 32'd0;
        m_shadow[i] = 32'd0; m_pend[i] = 1'b1; m_fc[i] = 16'd0;
    endtask

    // Advance by one clk edge given the inputs seen at that edge.
    task automatic model_step(input int i, input logic [31:0] p, input logic f);
        if (m_busy[i]) begin
            if (m_k[i] == 0) begin
                m_word[i] = p; m_shadow[i] = p; m_pend[i] = f;
            end else if (f) begin
                m_pend[i] = 1'b1;
            end
            m_k[i]++;
            if (m_k[i] == flen(i)) begin
                m_busy[i] = 1'b0;
                m_fc[i]   = m_fc[i] + 16'd1;
            end
        end else begin
            if (m_pend[i] || f || (p != m_shadow[i])) begin
                m_busy[i] = 1'b1; m_k[i] = 0;
            end
            if (f) m_pend[i] = 1'b1;
        end
    endtask

    task automatic model_compare(input int i, input logic b, input logic s, input logic d,
                                 input logic l, input logic [15:0] fc);
        int   dv, se, k, bi;
        logic eb, es, el, ed, mask;
        dv = divv(i); se = 1 + 2 * dv * W; k = m_k[i];
        eb = m_busy[i]; es = 1'b0; el = 1'b0; ed = 1'b0; mask = 1'b0;
        if (eb) begin
            es = (k >= 1) && (k < se) && ((((k - 1) / dv) % 2) == 1);
            el = (k >= se);
            if (k >= 1 && k < se) begin
                bi   = (k - 1) / (2 * dv);
                mask = 1'b1;
                ed   = m_word[i][(i == 0) ? (W - 1 - bi) : bi];
            end
        end
        check((i == 0) ? "cycle_dut1" : "cycle_dut2",
              {12'd0, b, s, l, d & mask, fc}, {12'd0, eb, es, el, ed, m_fc[i]});
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!reset_n) begin
            model_reset(0);
            model_reset(1);
        end
        model_compare(0, busy1, sclk1, sdata1, latch1, fc1);
        model_compare(1, busy2, sclk2, sdata2, latch2, fc2);
        if (reset_n) begin
            model_step(0, pw1, fu1);
            model_step(1, pw2, fu2);
        end
    end

    // ---------------- wire-level monitor for dut1 (rebuilds shifted words)
    logic        prev_sclk1 = 1'b0, prev_latch1 = 1'b0;
    logic [31:0] cap_word = 32'd0;
    int          cap_bits = 0, latch_w = 0, last_latch_w = 0, last_bits = 0;
    logic [31:0] frames[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            cap_bits = 0; cap_word = 32'd0; latch_w = 0;
            prev_sclk1 = 1'b0; prev_latch1 = 1'b0;
        end else begin
            if (sclk1 && !prev_sclk1) begin
                cap_word = {cap_word[30:0], sdata1};
                cap_bits++;
            end
            if (latch1) latch_w++;
            if (latch1 && !prev_latch1) begin
                frames.push_back(cap_word);
                last_bits = cap_bits;
            end
            if (!latch1 && prev_latch1) begin
                last_latch_w = latch_w; latch_w = 0; cap_bits = 0;
            end
            prev_sclk1 = sclk1; prev_latch1 = latch1;
        end
    end

    // ---------------- helpers
    function automatic logic busyv(input int i);
        return (i == 0) ? busy1 : busy2;
    endfunction

    task automatic wait_level(input int i, input logic lvl, input int budget, input string nm);
        int t = 0;
        @(negedge clk);
        while (busyv(i) !== lvl && t < budget) begin
            @(negedge clk);
            t++;
        end
        #1;
        if (busyv(i) !== lvl) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timeout waiting for busy=%0b", nm, lvl);
        end
    endtask

    // Waits for a frame, returns its busy length and first bit on a rising sclk.
    task automatic measure(input int i, output int len, output logic fb);
        bit got = 1'b0;
        len = 0; fb = 1'b0;
        wait_level(i, 1'b1, 600, "frame_start");
        while (busyv(i) === 1'b1 && len < 2000) begin
            len++;
            if (!got && ((i == 0) ? sclk1 : sclk2)) begin
                fb  = (i == 0) ? sdata1 : sdata2;
                got = 1'b1;
            end
            @(negedge clk);
        end
        #1;
    endtask

    task automatic pulse_fu1();
        @(posedge clk); #1 fu1 = 1'b1;
        @(posedge clk); #1 fu1 = 1'b0;
    endtask

    int   len, cnt, nb;
    logic fb;

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        reset_n = 1'b0; pw1 = 32'd0; pw2 = 32'd0; fu1 = 1'b0; fu2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {12'd0, sclk1, sdata1, latch1, busy1, fc1}, 32'd0);
        @(posedge clk); #2 reset_n = 1'b1;

        // First frame after reset transmits zeros.
        measure(0, len, fb);
        check("frame1_len", 32'(len), 32'd261);
        check("frame1_count", {16'd0, fc1}, 32'd1);
        check("frame1_latch_w", 32'(last_latch_w), 32'd4);
        check("frame1_frames", 32'(frames.size()), 32'd1);
        check("frame1_word", frames[0], 32'h0000_0000);

        // New word, with three rapid updates during its frame.
        @(posedge clk); #1 pw1 = 32'hA5A5_0F0F;
        wait_level(0, 1'b1, 10, "a5_start");
        repeat (30) @(posedge clk); #1 pw1 = 32'h1111_1111;
        repeat (30) @(posedge clk); #1 pw1 = 32'h2222_2222;
        repeat (30) @(posedge clk); #1 pw1 = 32'h3333_3333;
        wait_level(0, 1'b0, 400, "a5_end");
        check("a5_word", frames[frames.size() - 1], 32'hA5A5_0F0F);
        check("a5_bits", 32'(last_bits), 32'd32);
        check("a5_count", {16'd0, fc1}, 32'd2);
        wait_level(0, 1'b1, 10, "c33_start");
        wait_level(0, 1'b0, 400, "c33_end");
        check("c33_word", frames[frames.size() - 1], 32'h3333_3333);
        check("c33_count", {16'd0, fc1}, 32'd3);
        cnt = 0;
        foreach (frames[j]) if (frames[j] == 32'h1111_1111 || frames[j] == 32'h2222_2222) cnt++;
        check("dropped_words", 32'(cnt), 32'd0);

        // force_update: one from idle, then two while busy give one more.
        repeat (5) @(posedge clk);
        pulse_fu1();
        wait_level(0, 1'b1, 10, "force_start");
        repeat (40) @(posedge clk);
        pulse_fu1();
        repeat (40) @(posedge clk);
        pulse_fu1();
        wait_level(0, 1'b0, 400, "force_end1");
        wait_level(0, 1'b1, 10, "force_extra");
        wait_level(0, 1'b0, 400, "force_end2");
        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (busy1) cnt++;
        end
        check("quiet_1000", 32'(cnt), 32'd0);
        check("force_count", {16'd0, fc1}, 32'd5);
        check("force_frames", 32'(frames.size()), 32'd5);
        check("force_word", frames[4], 32'h3333_3333);

        // Reset in the middle of bit 17.
        @(posedge clk); #1 pw1 = 32'h0F0F_1234;
        cnt = 0;
        while (cap_bits != 17 && cnt < 1000) begin
            @(negedge clk); #1;
            cnt++;
        end
        check("reach_bit17", 32'(cap_bits), 32'd17);
        nb = frames.size();
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        check("async_rst_dut1", {12'd0, sclk1, sdata1, latch1, busy1, fc1}, 32'd0);
        check("async_rst_dut2", {12'd0, sclk2, sdata2, latch2, busy2, fc2}, 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 reset_n = 1'b1;
        measure(0, len, fb);
        check("resend_len", 32'(len), 32'd261);
        check("resend_frames", 32'(frames.size()), 32'(nb + 1));
        check("resend_word", frames[frames.size() - 1], 32'h0F0F_1234);
        check("resend_count", {16'd0, fc1}, 32'd1);

        // CLK_DIV=1, LSB first.
        wait_level(1, 1'b0, 200, "dut2_idle");
        @(posedge clk); #1 pw2 = 32'h0000_0001;
        measure(1, len, fb);
        check("dut2_len", 32'(len), 32'd66);
        check("dut2_first_bit", {31'd0, fb}, 32'd1);
        check("dut2_count", {16'd0, fc2}, 32'd2);
        @(posedge clk); #1;
        force dut2.frame_count_q = 16'hFFFF;
        m_fc[1] = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1 release dut2.frame_count_q;
        @(negedge clk); #1;
        check("dut2_preset", {16'd0, fc2}, 32'h0000_FFFF);
        @(posedge clk); #1 pw2 = 32'h0000_0002;
        measure(1, len, fb);
        check("dut2_wrap", {16'd0, fc2}, 32'd0);

        // Randomized updates and retransmit pulses on both instances.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            fu1 = ($urandom_range(199) == 0);
            fu2 = ($urandom_range(49) == 0);
            if ($urandom_range(59) == 0) pw1 = $urandom;
            if ($urandom_range(19) == 0) pw2 = $urandom;
        end
        @(posedge clk); #1 fu1 = 1'b0; fu2 = 1'b0;
        repeat (700) @(negedge clk);
        #1;
        check("final_word", frames[frames.size() - 1], pw1);
        check("final_idle", {30'd0, busy1, busy2}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
